// File: rtl/module_counter_pkg.sv
// Shared types for the mode counter: counting modes and direction encodings.
package module_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/module_prescaler.sv
// Divides the clock into count steps: step_o is high on every PRESCALE-th enabled cycle.
module module_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  // A clear (load or mode change) suppresses the step so the restart is clean.
  assign step_o = en_i && !clr_i && (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
    end else if (en_i) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/module_counter_mode.sv
// Prescaled WIDTH-bit counter with up, down, ping-pong and one-shot modes,
// synchronous clamped load and single-cycle tick/terminal strobes.
module module_counter_mode
  import module_counter_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int WIDTH    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             dir_o
);

  mode_e            mode_q;
  mode_e            mode_in;
  logic             mode_chg;
  logic             step;
  logic [WIDTH-1:0] count_q;
  logic             dir_q;
  logic             done_q;
  logic             tick_q;
  logic             tc_q;
  logic [WIDTH-1:0] load_clamped;
  logic             new_dir;

  logic [WIDTH-1:0] step_cnt;
  logic             step_dir;
  logic             step_tc;
  logic             step_done;

  assign mode_in      = mode_e'(mode_i);
  assign mode_chg     = (mode_q != mode_in);
  assign load_clamped = (load_val_i > max_i) ? max_i : load_val_i;
  assign new_dir      = (mode_in == MODE_DOWN) ? DIR_DOWN : DIR_UP;

  module_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en_i),
    .clr_i (load_i | mode_chg),
    .step_o(step)
  );

  // Next count/direction/done for a step in the currently registered mode.
  always_comb begin
    step_cnt  = count_q;
    step_dir  = dir_q;
    step_tc   = 1'b0;
    step_done = done_q;
    case (mode_q)
      MODE_UP: begin
        if (count_q >= max_i) begin
          step_cnt = '0;
          step_tc  = 1'b1;
        end else begin
          step_cnt = count_q + WIDTH'(1);
        end
      end
      MODE_DOWN: begin
        if (count_q == '0 || count_q > max_i) begin
          step_cnt = max_i;
          step_tc  = 1'b1;
        end else begin
          step_cnt = count_q - WIDTH'(1);
        end
      end
      MODE_PINGPONG: begin
        if (count_q > max_i) begin
          step_cnt = max_i;
          step_dir = DIR_DOWN;
          step_tc  = 1'b1;
        end else if (dir_q == DIR_UP) begin
          if (count_q == max_i) begin
            step_cnt = (max_i == '0) ? '0 : max_i - WIDTH'(1);
            step_dir = DIR_DOWN;
            step_tc  = 1'b1;
          end else begin
            step_cnt = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            step_cnt = (max_i == '0) ? '0 : WIDTH'(1);
            step_dir = DIR_UP;
            step_tc  = 1'b1;
          end else begin
            step_cnt = count_q - WIDTH'(1);
          end
        end
      end
      MODE_ONESHOT: begin
        // A count already at or past the terminal finishes on the next step.
        if (!done_q) begin
          if (count_q >= max_i || (count_q + WIDTH'(1)) == max_i) begin
            step_cnt  = max_i;
            step_done = 1'b1;
            step_tc   = 1'b1;
          end else begin
            step_cnt = count_q + WIDTH'(1);
          end
        end
      end
    endcase
  end

  // Load beats mode change beats step; the mode register also follows a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_UP;
      count_q <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      if (load_i) begin
        count_q <= load_clamped;
        mode_q  <= mode_in;
        done_q  <= 1'b0;
        dir_q   <= new_dir;
      end else if (mode_chg) begin
        mode_q <= mode_in;
        done_q <= 1'b0;
        dir_q  <= new_dir;
      end else if (step) begin
        count_q <= step_cnt;
        dir_q   <= step_dir;
        done_q  <= step_done;
        tick_q  <= 1'b1;
        tc_q    <= step_tc;
      end
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;
  assign dir_o   = dir_q;

endmodule
